timed_stream_out: RTL and testbench
===================================

# timed_stream_out

Bridge from the fixed-latency, go-pulse timed domain to a ready/valid stream consumer. A timed producer presents a value on `in` in the cycle `_go` is high and gets no backpressure. The block buffers each such value in a small FIFO and drains it through a valid/ready handshake. It is the reading end of the write-enable capture protocol used by the register primitives: the consumer-side counterpart that can stall. It also exports occupancy so schedulers can budget go pulses statically.

## Interface

- `WIDTH`, 32: data width in bits, ≥1.
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `_go` in 1: producer strobe; `in` is sampled as a push in this cycle.
- `in` in `WIDTH`: producer data, meaningful only while `_go`=1.
- `out_valid` in/out: out 1; high when FIFO holds ≥1 entry.
- `out_ready` in 1: consumer accepts the head entry when high together with `out_valid`.
- `out` out `WIDTH`: head entry. Forced to 0 whenever `out_valid`=0.
- `count` out `$clog2(DEPTH)+1`: current occupancy, 0..`DEPTH`.
- `full` out 1: `count`==`DEPTH`.
- `overflow` out 1: sticky error flag, set when a push is dropped.

## Operation

- Storage: `DEPTH`×`WIDTH` array; read pointer and write pointer, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`; separate occupancy counter.
- Pop: `pop = out_valid && out_ready`. Advances the read pointer and decrements `count`.
- Push: `push = _go && (!full || pop)`. Writes `in` at the write pointer, advances it and increments `count`.
- Simultaneous push and pop:
  - `count` unchanged.
  - Both pointers advance.
  - Allowed when full: the slot freed by the pop is reused in the same edge.
- Dropped push: `_go && full && !pop`.
  - `in` is discarded; no pointer or count change.
  - `overflow` is set to 1 and stays 1 until `reset`.
- No bypass: a value pushed into an empty FIFO is not visible on `out` in the same cycle.
- `out_ready` while `out_valid`=0 has no effect.
- `out = out_valid ? mem[rd_ptr] : 0`. Storage contents need no reset.
- `out_valid = (count != 0)`; `full = (count == DEPTH)`. Both are derived from registered state only; no combinational path from `_go` or `out_ready`.
- Handshake rule for the consumer side: once `out_valid` rises, it and `out` stay stable until popped. The block never withdraws an entry.
- Reset:
  - Pointers = 0 and `count` = 0.
  - `overflow` = 0; hence `out_valid` = 0, `out` = 0, `full` = 0.
  - Reset has priority over `_go`/`out_ready` in the same cycle; in-flight entries are discarded.

## Timing

- Push latency: `_go` at edge t makes the entry visible, `out_valid`=1 after edge t, i.e. in cycle t+1.
- Throughput: one push and one pop per cycle, sustained indefinitely with `out_ready` held high.
- `count` and `full` reflect all pushes and pops through the previous edge.
- `overflow` rises in the cycle after the dropped `_go`.
- First-cycle behaviour after reset deasserts: the block accepts `_go` immediately.

## Test plan

- **Reset values:** hold `reset` 2 cycles with `_go`=1, `in`=0xDEAD → after release `out_valid`=0, `out`=0, `count`=0, `full`=0, `overflow`=0; nothing was stored.
- **Ordering and latency:** DEPTH=4, `out_ready`=0, pulse `_go` with 0x11, 0x22, 0x33 on consecutive cycles.
  - `out_valid`=1 one cycle after the first pulse.
  - `count` reaches 3.
  - Then raise `out_ready` → `out` reads 0x11, 0x22, 0x33 on successive cycles, then `out_valid`=0 and `out`=0.
- **Full, drop, sticky:** fill with 1,2,3,4 (`full`=1, `count`=4), then `_go` with 5 and `out_ready`=0.
  - 5 is dropped: `overflow`=1 next cycle, `count` stays 4.
  - Drain returns 1,2,3,4 only.
  - `overflow` stays 1 after the drain, until `reset`.
- **Push+pop at full:** fill with 1..4, then one cycle with `_go`=1 (`in`=9) and `out_ready`=1.
  - `count` stays 4 and `overflow` stays 0.
  - Drain yields 2,3,4,9.
- **Pointer wrap:** DEPTH=4, 10 cycles of `_go` with `in`=cycle index and `out_ready`=1 throughout.
  - Outputs are 0..9 in order, each one cycle after its push.
  - `count` never exceeds 1.
- **Reset mid-operation:** with `count`=3, assert `reset` together with `_go` and `out_ready` → next cycle `count`=0, `out_valid`=0, `overflow`=0; the next push's value is the first value read out.

Source files
------------

// File: rtl/timed_stream_out.sv
// Timed-to-stream bridge: buffers go-strobed producer values in a small FIFO
// and drains them through a valid/ready handshake, exporting occupancy.
module timed_stream_out #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     _go,
  input  logic [WIDTH-1:0]         in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Flags come only from registered occupancy, so the consumer sees no
  // combinational path from _go or out_ready.
  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign out       = out_valid ? mem[rd_ptr] : '0;

  // A pop in the same cycle frees the head slot, letting a push land while full.
  assign pop  = out_valid & out_ready;
  assign push = _go & (~full | pop);

  // Pointer, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (_go && !push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; valid is governed by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in;
  end

endmodule

// File: tb/tb_timed_stream_out.sv
// Directed self-checking bench for timed_stream_out (WIDTH=32, DEPTH=4).
module tb_timed_stream_out;

  logic        clk;
  logic        reset;
  logic        go;
  logic [31:0] d_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d_out;
  logic [2:0]  count;
  logic        full;
  logic        overflow;

  int errors;
  int checks;

  timed_stream_out #(.WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    ._go       (go),
    .in        (d_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (d_out),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] v);
    go = 1'b1; d_in = v;
    tick();
    go = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b1; d_in = 32'hDEAD; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0; go = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (d_out !== 32'h0) begin errors++; $display("FAIL reset_out got=%h exp=0", d_out); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_nothing_stored got=%0b exp=0", out_valid); end
  endtask

  task automatic test_order();
    out_ready = 1'b0;
    push_one(32'h11);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL order_latency_valid got=%0b exp=1", out_valid); end
    checks++; if (d_out !== 32'h11) begin errors++; $display("FAIL order_head got=%h exp=11", d_out); end
    go = 1'b1; d_in = 32'h22; tick();
    d_in = 32'h33; tick();
    go = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL order_count got=%0d exp=3", count); end
    out_ready = 1'b1;
    tick();
    checks++; if (d_out !== 32'h22) begin errors++; $display("FAIL order_second got=%h exp=22", d_out); end
    tick();
    checks++; if (d_out !== 32'h33) begin errors++; $display("FAIL order_third got=%h exp=33", d_out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_empty_valid got=%0b exp=0", out_valid); end
    checks++; if (d_out !== 32'h0) begin errors++; $display("FAIL order_empty_out got=%h exp=0", d_out); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_drop();
    for (int i = 1; i <= 4; i++) push_one(32'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL drop_full got=%0b exp=1", full); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL drop_count_full got=%0d exp=4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL drop_no_overflow_yet got=%0b exp=0", overflow); end
    push_one(32'd5);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow got=%0b exp=1", overflow); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL drop_count_kept got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (d_out !== 32'(i)) begin errors++; $display("FAIL drop_drain[%0d] got=%0d exp=%0d", i, d_out, i); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_drained_valid got=%0b exp=0", out_valid); end
    out_ready = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_sticky got=%0b exp=1", overflow); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL drop_reset_clears got=%0b exp=0", overflow); end
  endtask

  task automatic test_push_pop_full();
    for (int i = 1; i <= 4; i++) push_one(32'(i));
    go = 1'b1; d_in = 32'd9; out_ready = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL pp_count got=%0d exp=4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow got=%0b exp=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_v;
      exp_v = (i == 3) ? 32'd9 : 32'(i + 2);
      checks++; if (d_out !== exp_v) begin errors++; $display("FAIL pp_drain[%0d] got=%0d exp=%0d", i, d_out, exp_v); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got=%0b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      go = 1'b1; d_in = 32'(i);
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d] got=%0b exp=1", i, out_valid); end
      checks++; if (d_out !== 32'(i)) begin errors++; $display("FAIL wrap_out[%0d] got=%0d exp=%0d", i, d_out, i); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count[%0d] got=%0d exp=1", i, count); end
    end
    go = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_end_valid got=%0b exp=0", out_valid); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_ready_on_empty got=%0d exp=0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 4; i++) push_one(32'(i + 16));
    push_one(32'h55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_pre_overflow got=%0b exp=1", overflow); end
    reset = 1'b1; go = 1'b1; d_in = 32'h77; out_ready = 1'b1;
    tick();
    reset = 1'b0; go = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%0b exp=0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got=%0b exp=0", overflow); end
    push_one(32'hAB);
    checks++; if (d_out !== 32'hAB) begin errors++; $display("FAIL mid_first_out got=%h exp=ab", d_out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL mid_first_count got=%0d exp=1", count); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; go = 1'b0; d_in = '0; out_ready = 1'b0;
    test_reset();
    test_order();
    test_full_drop();
    test_push_pop_full();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
